prbs_checker: RTL and testbench

- Serial PRBS checker that receives the bit stream produced by the team's Fibonacci LFSR generator.
- Self-synchronises to the incoming sequence and declares lock, then flags and counts bit errors.
- Sits at the receive end of link and BIST loops, opposite the LFSR source.

---
 rtl/prbs_checker_if.sv | 41 ++++
 rtl/prbs_checker.sv | 149 ++++++++++++++
 tb/tb_prbs_checker.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prbs_checker_if.sv
// Purpose: bundles the serial input, control and status lines of the PRBS checker.
// Latency: none, this is wiring only.
// Backpressure: none; din_valid qualifies din and the checker always accepts.
//
// Signals:
//   din        received serial bit (source -> checker)
//   din_valid  din is meaningful this cycle (source -> checker)
//   err_clr    synchronous clear of the error total (source -> checker)
//   locked     checker is synchronised to the sequence (checker -> source)
//   err        one-cycle pulse for a counted bit error (checker -> source)
//   err_count  saturating error total (checker -> source)
interface prbs_checker_if #(
    parameter int CNT_W = 16
);
    logic             din;
    logic             din_valid;
    logic             err_clr;
    logic             locked;
    logic             err;
    logic [CNT_W-1:0] err_count;

    // master: the side that supplies the stream and reads status
    modport master (
        output din,
        output din_valid,
        output err_clr,
        input  locked,
        input  err,
        input  err_count
    );

    // slave: the checker itself
    modport slave (
        input  din,
        input  din_valid,
        input  err_clr,
        output locked,
        output err,
        output err_count
    );
endinterface

// File: rtl/prbs_checker.sv
// Purpose: self-synchronising checker for a Fibonacci LFSR serial stream; locks, then flags and counts bit errors.
// Latency: locked/err/err_count are registered on the edge that samples the valid bit.
// Backpressure: none; every din_valid cycle is consumed, idle cycles hold all state.
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset; restarts acquisition from scratch
//   bus   prbs_checker_if.slave: din, din_valid, err_clr in; locked, err, err_count out
module prbs_checker #(
    parameter int               WIDTH         = 3,
    parameter logic [WIDTH-1:0] TAPS          = 3'b110,
    parameter int               LOCK_COUNT    = 4,
    parameter int               UNLOCK_THRESH = 3,
    parameter int               CNT_W         = 16
) (
    input  logic          clk,
    input  logic          rst,
    prbs_checker_if.slave bus
);

    localparam int FILL_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_CHECK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  r_q;
    logic [FILL_W-1:0] fill_q;
    logic [7:0]        match_q;
    logic [7:0]        miss_q;
    logic              locked_q;
    logic              err_q;
    logic [CNT_W-1:0]  err_count_q;

    logic              fb_bit;
    logic              bit_ok;
    logic              r_nz;
    logic              count_err;
    logic [FILL_W-1:0] fill_inc;
    logic [7:0]        match_inc;
    logic [7:0]        miss_inc;
    logic [WIDTH-1:0]  r_line_d;
    logic [WIDTH-1:0]  r_pred_d;
    logic [CNT_W-1:0]  err_count_d;

    always_comb begin
        // r holds the last WIDTH bits, oldest in the MSB, so the next
        // expected bit is simply the tap parity of r.
        fb_bit    = ^(r_q & TAPS);
        bit_ok    = (bus.din == fb_bit);
        r_nz      = |r_q;
        fill_inc  = fill_q + 1'b1;
        match_inc = match_q + 8'd1;
        miss_inc  = miss_q + 8'd1;
        r_line_d  = {r_q[WIDTH-2:0], bus.din};
        r_pred_d  = {r_q[WIDTH-2:0], fb_bit};

        count_err = bus.din_valid && (state_q == ST_LOCKED) && !bit_ok;

        // A clear that coincides with a counted error leaves that error in
        // the total rather than losing it.
        err_count_d = err_count_q;
        if (bus.err_clr) begin
            err_count_d = count_err ? CNT_W'(1) : '0;
        end else if (count_err && !(&err_count_q)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SEARCH;
            r_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            miss_q      <= '0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q       <= count_err;
            err_count_q <= err_count_d;

            if (bus.din_valid) begin
                case (state_q)
                    ST_SEARCH: begin
                        r_q    <= r_line_d;
                        fill_q <= fill_inc;
                        if (fill_q == FILL_W'(WIDTH - 1)) begin
                            state_q <= ST_CHECK;
                            match_q <= '0;
                        end
                    end

                    ST_CHECK: begin
                        // Keep seeding from the line until enough predictions
                        // hold. An all-zero window never counts, otherwise an
                        // idle zero line would look like a valid sequence.
                        r_q <= r_line_d;
                        if (bit_ok && r_nz) begin
                            match_q <= match_inc;
                            if (match_inc == 8'(LOCK_COUNT)) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                                miss_q   <= '0;
                            end
                        end else begin
                            match_q <= '0;
                        end
                    end

                    ST_LOCKED: begin
                        // Free-run on the prediction so a corrupted bit does
                        // not poison the following predictions.
                        r_q <= r_pred_d;
                        if (!bit_ok) begin
                            miss_q <= miss_inc;
                            if (miss_inc == 8'(UNLOCK_THRESH)) begin
                                state_q  <= ST_SEARCH;
                                fill_q   <= '0;
                                match_q  <= '0;
                                miss_q   <= '0;
                                locked_q <= 1'b0;
                            end
                        end else begin
                            miss_q <= '0;
                        end
                    end

                    default: begin
                        state_q  <= ST_SEARCH;
                        fill_q   <= '0;
                        match_q  <= '0;
                        miss_q   <= '0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

    // A narrow counter keeps the saturation point reachable in a short run.
    localparam int TB_CNT_W = 4;

    logic clk;
    logic rst;

    prbs_checker_if #(.CNT_W(TB_CNT_W)) bus_if ();

    prbs_checker #(
        .WIDTH        (3),
        .TAPS         (3'b110),
        .LOCK_COUNT   (4),
        .UNLOCK_THRESH(3),
        .CNT_W        (TB_CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int vectors;
    int miscompares;
    int ph;
    bit pat [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1);
    end

    // Drive one cycle on the falling edge, then settle just after the rising edge.
    task automatic drive(input logic b, input logic v, input logic c);
        @(negedge clk);
        bus_if.din       = b;
        bus_if.din_valid = v;
        bus_if.err_clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic send_clean(input logic c);
        drive(pat[ph], 1'b1, c);
        ph = (ph + 1) % 7;
    endtask

    task automatic send_flip(input logic c);
        drive(~pat[ph], 1'b1, c);
        ph = (ph + 1) % 7;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst              = 1'b1;
        bus_if.din_valid = 1'b0;
        bus_if.err_clr   = 1'b0;
        bus_if.din       = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ph  = 0;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus_if.din       = 1'b0;
        bus_if.din_valid = 1'b0;
        bus_if.err_clr   = 1'b0;
        ph               = 0;
        #1;
        vectors++;
        if (bus_if.locked !== 1'b0 || bus_if.err !== 1'b0 || bus_if.err_count !== 4'd0) begin
            $display("FAIL reset: locked=%b err=%b cnt=%0d, want 0 0 0",
                     bus_if.locked, bus_if.err, bus_if.err_count);
            miscompares++;
        end
        #9;
        rst = 1'b0;
    endtask

    task automatic test_lock();
        for (int i = 1; i <= 50; i++) begin
            send_clean(1'b0);
            vectors++;
            if (bus_if.locked !== (i >= 7)) begin
                $display("FAIL lock bit %0d: locked=%b want %b", i, bus_if.locked, (i >= 7));
                miscompares++;
            end
            vectors++;
            if (bus_if.err !== 1'b0) begin
                $display("FAIL lock_err bit %0d: err=%b want 0", i, bus_if.err);
                miscompares++;
            end
        end
        vectors++;
        if (bus_if.err_count !== 4'd0) begin
            $display("FAIL lock_cnt: cnt=%0d want 0", bus_if.err_count);
            miscompares++;
        end
    endtask

    task automatic test_single_err();
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            if (i == 20) send_flip(1'b0);
            else         send_clean(1'b0);
            vectors++;
            if (bus_if.err !== (i == 20)) begin
                $display("FAIL single_err bit %0d: err=%b want %b", i, bus_if.err, (i == 20));
                miscompares++;
            end
            vectors++;
            if (bus_if.locked !== (i >= 7)) begin
                $display("FAIL single_lock bit %0d: locked=%b want %b", i, bus_if.locked, (i >= 7));
                miscompares++;
            end
            vectors++;
            if (bus_if.err_count !== ((i >= 20) ? 4'd1 : 4'd0)) begin
                $display("FAIL single_cnt bit %0d: cnt=%0d want %0d", i, bus_if.err_count, (i >= 20) ? 1 : 0);
                miscompares++;
            end
        end
    endtask

    task automatic test_zeros();
        do_reset();
        for (int i = 1; i <= 30; i++) begin
            drive(1'b0, 1'b1, 1'b0);
            vectors++;
            if (bus_if.locked !== 1'b0 || bus_if.err !== 1'b0) begin
                $display("FAIL zeros bit %0d: locked=%b err=%b want 0 0", i, bus_if.locked, bus_if.err);
                miscompares++;
            end
        end
        vectors++;
        if (bus_if.err_count !== 4'd0) begin
            $display("FAIL zeros_cnt: cnt=%0d want 0", bus_if.err_count);
            miscompares++;
        end
    endtask

    task automatic test_unlock();
        logic       exp_lock;
        logic [3:0] exp_cnt;
        do_reset();
        for (int i = 1; i <= 25; i++) begin
            if (i >= 11 && i <= 13) send_flip(1'b0);
            else                    send_clean(1'b0);
            exp_lock = (i >= 7 && i <= 12) || (i >= 20);
            exp_cnt  = (i < 11) ? 4'd0 : (i >= 13) ? 4'd3 : 4'(i - 10);
            vectors++;
            if (bus_if.locked !== exp_lock) begin
                $display("FAIL unlock_lock bit %0d: locked=%b want %b", i, bus_if.locked, exp_lock);
                miscompares++;
            end
            vectors++;
            if (bus_if.err !== (i >= 11 && i <= 13)) begin
                $display("FAIL unlock_err bit %0d: err=%b want %b", i, bus_if.err, (i >= 11 && i <= 13));
                miscompares++;
            end
            vectors++;
            if (bus_if.err_count !== exp_cnt) begin
                $display("FAIL unlock_cnt bit %0d: cnt=%0d want %0d", i, bus_if.err_count, exp_cnt);
                miscompares++;
            end
        end
    endtask

    task automatic test_err_clr();
        logic [3:0] exp_cnt;
        do_reset();
        for (int i = 0; i < 7; i++) send_clean(1'b0);
        for (int k = 1; k <= 5; k++) begin
            send_flip(1'b0);
            vectors++;
            if (bus_if.err !== 1'b1 || bus_if.err_count !== 4'(k)) begin
                $display("FAIL clr_pre %0d: err=%b cnt=%0d want 1 %0d", k, bus_if.err, bus_if.err_count, k);
                miscompares++;
            end
            send_clean(1'b0);
        end
        send_flip(1'b1);
        vectors++;
        if (bus_if.err !== 1'b1 || bus_if.err_count !== 4'd1) begin
            $display("FAIL clr_with_err: err=%b cnt=%0d want 1 1", bus_if.err, bus_if.err_count);
            miscompares++;
        end
        send_clean(1'b1);
        vectors++;
        if (bus_if.err !== 1'b0 || bus_if.err_count !== 4'd0) begin
            $display("FAIL clr_alone: err=%b cnt=%0d want 0 0", bus_if.err, bus_if.err_count);
            miscompares++;
        end
        for (int k = 1; k <= 18; k++) begin
            send_flip(1'b0);
            exp_cnt = (k >= 15) ? 4'hF : 4'(k);
            vectors++;
            if (bus_if.err !== 1'b1 || bus_if.err_count !== exp_cnt) begin
                $display("FAIL sat %0d: err=%b cnt=%0d want 1 %0d", k, bus_if.err, bus_if.err_count, exp_cnt);
                miscompares++;
            end
            send_clean(1'b0);
        end
        vectors++;
        if (bus_if.locked !== 1'b1 || bus_if.err_count !== 4'hF) begin
            $display("FAIL sat_hold: locked=%b cnt=%0d want 1 15", bus_if.locked, bus_if.err_count);
            miscompares++;
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        for (int i = 0; i < 10; i++) send_clean(1'b0);
        send_flip(1'b0);
        vectors++;
        if (bus_if.locked !== 1'b1 || bus_if.err !== 1'b1 || bus_if.err_count !== 4'd1) begin
            $display("FAIL rst_pre: locked=%b err=%b cnt=%0d want 1 1 1", bus_if.locked, bus_if.err, bus_if.err_count);
            miscompares++;
        end
        #1;
        rst = 1'b1;
        #1;
        vectors++;
        if (bus_if.locked !== 1'b0 || bus_if.err !== 1'b0 || bus_if.err_count !== 4'd0) begin
            $display("FAIL rst_async: locked=%b err=%b cnt=%0d want 0 0 0", bus_if.locked, bus_if.err, bus_if.err_count);
            miscompares++;
        end
        @(negedge clk);
        bus_if.din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            send_clean(1'b0);
            vectors++;
            if (bus_if.locked !== (i >= 7) || bus_if.err_count !== 4'd0) begin
                $display("FAIL rst_relock bit %0d: locked=%b cnt=%0d want %b 0", i, bus_if.locked, bus_if.err_count, (i >= 7));
                miscompares++;
            end
        end
    endtask

    task automatic test_gaps();
        int   n;
        logic prev_lock;
        do_reset();
        n = 0;
        while (n < 30) begin
            n++;
            if (n == 12) send_flip(1'b0);
            else         send_clean(1'b0);
            vectors++;
            if (bus_if.locked !== (n >= 7) || bus_if.err !== (n == 12) ||
                bus_if.err_count !== ((n >= 12) ? 4'd1 : 4'd0)) begin
                $display("FAIL gaps_valid bit %0d: locked=%b err=%b cnt=%0d want %b %b %0d", n,
                         bus_if.locked, bus_if.err, bus_if.err_count, (n >= 7), (n == 12), (n >= 12) ? 1 : 0);
                miscompares++;
            end
            prev_lock = bus_if.locked;
            drive(1'($urandom_range(0, 1)), 1'b0, 1'b0);
            vectors++;
            if (bus_if.err !== 1'b0 || bus_if.locked !== prev_lock ||
                bus_if.err_count !== ((n >= 12) ? 4'd1 : 4'd0)) begin
                $display("FAIL gaps_idle after %0d: locked=%b err=%b cnt=%0d want %b 0 %0d", n,
                         bus_if.locked, bus_if.err, bus_if.err_count, prev_lock, (n >= 12) ? 1 : 0);
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_lock();
        test_single_err();
        test_zeros();
        test_unlock();
        test_err_clr();
        test_rst_mid();
        test_gaps();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
